// File: rtl/pdl_pkg.sv
// Shared encodings for the PDL control stage: micro-op source/destination
// fields and the default buffer address width.
package pdl_pkg;

    localparam int PDL_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        SRC_NONE    = 2'd0,
        SRC_PTR     = 2'd1,
        SRC_PTR_POP = 2'd2,
        SRC_IDX     = 2'd3
    } pdl_src_e;

    // Codes 6 and 7 are unused and behave exactly like DST_NONE.
    typedef enum logic [2:0] {
        DST_NONE      = 3'd0,
        DST_PTR       = 3'd1,
        DST_PTR_PUSH  = 3'd2,
        DST_IDX       = 3'd3,
        DST_LOAD_PDLP = 3'd4,
        DST_LOAD_PDLX = 3'd5,
        DST_RSVD6     = 3'd6,
        DST_RSVD7     = 3'd7
    } pdl_dst_e;

    function automatic logic src_reads_ram(input pdl_src_e src);
        return src != SRC_NONE;
    endfunction

    function automatic logic dst_writes_ram(input pdl_dst_e dst);
        return (dst == DST_PTR) || (dst == DST_PTR_PUSH) || (dst == DST_IDX);
    endfunction

endpackage

// File: rtl/pdl_ctl_if.sv
// Micro-op handshake and PDL buffer control bundle between the issue stage
// (master) and pdl_ctl (slave).
interface pdl_ctl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  op_valid;
    logic [1:0]            op_src;
    logic [2:0]            op_dst;
    logic [ADDR_WIDTH-1:0] ob;
    logic [ADDR_WIDTH-1:0] pdla;
    logic                  prp;
    logic                  pwp;
    logic [ADDR_WIDTH-1:0] pdlptr;
    logic [ADDR_WIDTH-1:0] pdlidx;
    logic                  stall;
    logic                  rd_valid;

    modport master (
        output op_valid, op_src, op_dst, ob,
        input  pdla, prp, pwp, pdlptr, pdlidx, stall, rd_valid
    );

    modport slave (
        input  op_valid, op_src, op_dst, ob,
        output pdla, prp, pwp, pdlptr, pdlidx, stall, rd_valid
    );
endinterface

// File: rtl/pdl_ptr_next.sv
// Combinational next-pointer / next-index / address calculator for one
// micro-op. Pop is applied before push; a pointer load overrides the pop.
module pdl_ptr_next
    import pdl_pkg::*;
#(
    parameter int ADDR_WIDTH = PDL_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] ptr,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [ADDR_WIDTH-1:0] ob,
    input  pdl_src_e              src,
    input  pdl_dst_e              dst,
    output logic [ADDR_WIDTH-1:0] ptr_nxt,
    output logic [ADDR_WIDTH-1:0] idx_nxt,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_en
);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] popped;

    always_comb begin
        // Reads always see the pointer as it was before this op's pop.
        popped  = (src == SRC_PTR_POP) ? ptr - ONE : ptr;
        rd_addr = (src == SRC_IDX) ? idx : ptr;
        ptr_nxt = popped;
        idx_nxt = idx;
        wr_addr = popped;
        wr_en   = dst_writes_ram(dst);
        case (dst)
            DST_PTR_PUSH: begin
                ptr_nxt = popped + ONE;
                wr_addr = popped + ONE;
            end
            DST_IDX:       wr_addr = idx;
            DST_LOAD_PDLP: ptr_nxt = ob;
            DST_LOAD_PDLX: idx_nxt = ob;
            default:       ;
        endcase
    end

endmodule

// File: rtl/pdl_ctl.sv
// PDL control stage: owns pdlptr/pdlidx, drives the buffer RAM ports, delays
// each write by one cycle to meet L data, and stalls reads behind a pending write.
module pdl_ctl
    import pdl_pkg::*;
#(
    parameter int ADDR_WIDTH = PDL_ADDR_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    pdl_ctl_if.slave bus
);
    logic [ADDR_WIDTH-1:0] pdlptr_q, pdlptr_d;
    logic [ADDR_WIDTH-1:0] pdlidx_q, pdlidx_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_pend_q, wr_pend_d;
    logic                  rd_valid_q, rd_valid_d;

    pdl_src_e              src;
    pdl_dst_e              dst;
    logic                  has_src;
    logic                  stall;
    logic                  accept;
    logic                  prp;
    logic [ADDR_WIDTH-1:0] pdla;

    logic [ADDR_WIDTH-1:0] ptr_nxt;
    logic [ADDR_WIDTH-1:0] idx_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] op_wr_addr;
    logic                  op_wr_en;

    always_comb begin
        src = pdl_src_e'(bus.op_src);
        dst = pdl_dst_e'(bus.op_dst);
    end

    pdl_ptr_next #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ptr_next (
        .ptr    (pdlptr_q),
        .idx    (pdlidx_q),
        .ob     (bus.ob),
        .src    (src),
        .dst    (dst),
        .ptr_nxt(ptr_nxt),
        .idx_nxt(idx_nxt),
        .rd_addr(rd_addr),
        .wr_addr(op_wr_addr),
        .wr_en  (op_wr_en)
    );

    // The RAM has a single address; a pending write owns it, so any op that
    // needs a read waits one cycle. Dest-only ops still flow.
    always_comb begin
        has_src = src_reads_ram(src);
        stall   = bus.op_valid & wr_pend_q & has_src;
        accept  = bus.op_valid & ~stall & reset;
        prp     = accept & has_src;
        if (wr_pend_q) begin
            pdla = wr_addr_q;
        end else if (prp) begin
            pdla = rd_addr;
        end else begin
            pdla = pdlptr_q;
        end
    end

    always_comb begin
        pdlptr_d   = pdlptr_q;
        pdlidx_d   = pdlidx_q;
        wr_addr_d  = wr_addr_q;
        wr_pend_d  = 1'b0;
        rd_valid_d = prp;
        if (accept) begin
            pdlptr_d = ptr_nxt;
            pdlidx_d = idx_nxt;
            if (op_wr_en) begin
                wr_pend_d = 1'b1;
                wr_addr_d = op_wr_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pdlptr_q   <= '0;
            pdlidx_q   <= '0;
            wr_addr_q  <= '0;
            wr_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            pdlptr_q   <= pdlptr_d;
            pdlidx_q   <= pdlidx_d;
            wr_addr_q  <= wr_addr_d;
            wr_pend_q  <= wr_pend_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.pdla     = pdla;
    assign bus.prp      = prp;
    assign bus.pwp      = wr_pend_q;
    assign bus.pdlptr   = pdlptr_q;
    assign bus.pdlidx   = pdlidx_q;
    assign bus.stall    = stall;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_pdl_ctl.sv
// Bench for pdl_ctl: directed scenarios with literal expectations plus a
// randomized run compared each cycle against a stack-level reference model.
`timescale 1ns/1ps
module tb_pdl_ctl;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    localparam int S_NONE = 0, S_PTR = 1, S_POP = 2, S_IDX = 3;
    localparam int D_NONE = 0, D_PTR = 1, D_PUSH = 2, D_IDX = 3, D_LDP = 4, D_LDX = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pdl_ctl_if #(.ADDR_WIDTH(AW)) bus ();

    pdl_ctl #(.ADDR_WIDTH(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the PDL seen as a stack pointer, an index and at most
    // one write waiting for its L data.
    int m_ptr   = 0;
    int m_idx   = 0;
    int m_paddr = 0;
    bit m_pend  = 0;
    bit m_rdv   = 0;

    typedef struct {
        bit stall;
        bit acc;
        bit prp;
        bit pwp;
        int pdla;
    } exp_t;

    function automatic exp_t model_eval();
        exp_t e;
        bit   reads;
        reads   = (int'(bus.op_src) != S_NONE);
        e.stall = bus.op_valid && m_pend && reads;
        e.acc   = bus.op_valid && !e.stall;
        e.prp   = e.acc && reads;
        e.pwp   = m_pend;
        if (m_pend)       e.pdla = m_paddr;
        else if (e.prp)   e.pdla = (int'(bus.op_src) == S_IDX) ? m_idx : m_ptr;
        else              e.pdla = m_ptr;
        return e;
    endfunction

    always @(posedge clk or negedge reset) begin
        exp_t e;
        int   p;
        int   wa;
        bit   w;
        if (!reset) begin
            m_ptr = 0; m_idx = 0; m_paddr = 0; m_pend = 0; m_rdv = 0;
        end else begin
            e  = model_eval();
            w  = 0;
            wa = 0;
            m_rdv = e.prp;
            if (e.acc) begin
                p = m_ptr;
                if (int'(bus.op_src) == S_POP) p = (p + DEPTH - 1) % DEPTH;
                case (int'(bus.op_dst))
                    D_PTR:  begin w = 1; wa = p; end
                    D_PUSH: begin p = (p + 1) % DEPTH; w = 1; wa = p; end
                    D_IDX:  begin w = 1; wa = m_idx; end
                    D_LDP:  p = int'(bus.ob);
                    D_LDX:  m_idx = int'(bus.ob);
                    default: ;
                endcase
                m_ptr = p;
            end
            m_pend = w;
            if (w) m_paddr = wa;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            e = model_eval();
            chk("m_stall",    32'(bus.stall),    32'(e.stall));
            chk("m_prp",      32'(bus.prp),      32'(e.prp));
            chk("m_pwp",      32'(bus.pwp),      32'(e.pwp));
            chk("m_pdla",     32'(bus.pdla),     32'(e.pdla));
            chk("m_pdlptr",   32'(bus.pdlptr),   32'(m_ptr));
            chk("m_pdlidx",   32'(bus.pdlidx),   32'(m_idx));
            chk("m_rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
        end
    end

    task automatic drive(input int v, input int s, input int d, input int o);
        bus.op_valid = v[0];
        bus.op_src   = s[1:0];
        bus.op_dst   = d[2:0];
        bus.ob       = o[AW-1:0];
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        chk("rst_pdlptr",   32'(bus.pdlptr),   0);
        chk("rst_pdlidx",   32'(bus.pdlidx),   0);
        chk("rst_pwp",      32'(bus.pwp),      0);
        chk("rst_prp",      32'(bus.prp),      0);
        chk("rst_stall",    32'(bus.stall),    0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_pdla",     32'(bus.pdla),     0);
        nxt();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit held;
        int r;
        drive(0, 0, 0, 0);
        do_reset();

        // Push then pop
        drive(1, S_NONE, D_PUSH, 0);
        @(negedge clk); chk("t1_c1_stall", 32'(bus.stall), 0);
        nxt(); drive(1, S_POP, D_NONE, 0);
        @(negedge clk);
        chk("t1_c2_ptr",   32'(bus.pdlptr), 1);
        chk("t1_c2_pwp",   32'(bus.pwp),    1);
        chk("t1_c2_pdla",  32'(bus.pdla),   1);
        chk("t1_c2_stall", 32'(bus.stall),  1);
        chk("t1_c2_prp",   32'(bus.prp),    0);
        nxt();
        @(negedge clk);
        chk("t1_c3_prp",   32'(bus.prp),   1);
        chk("t1_c3_pdla",  32'(bus.pdla),  1);
        chk("t1_c3_stall", 32'(bus.stall), 0);
        nxt(); drive(0, 0, 0, 0);
        @(negedge clk);
        chk("t1_c4_rdv", 32'(bus.rd_valid), 1);
        chk("t1_c4_ptr", 32'(bus.pdlptr),   0);

        // Wrap on push from 1023 and pop from 0
        nxt(); drive(1, S_NONE, D_LDP, 1023);
        nxt(); drive(1, S_NONE, D_PUSH, 0);
        @(negedge clk); chk("t2_ld_ptr", 32'(bus.pdlptr), 1023);
        nxt(); drive(0, 0, 0, 0);
        @(negedge clk);
        chk("t2_push_pwp",  32'(bus.pwp),    1);
        chk("t2_push_pdla", 32'(bus.pdla),   0);
        chk("t2_push_ptr",  32'(bus.pdlptr), 0);
        nxt(); drive(1, S_POP, D_NONE, 0);
        @(negedge clk);
        chk("t2_pop_prp",  32'(bus.prp),  1);
        chk("t2_pop_pdla", 32'(bus.pdla), 0);
        nxt(); drive(0, 0, 0, 0);
        @(negedge clk); chk("t2_pop_ptr", 32'(bus.pdlptr), 1023);

        // Pop and push in one op
        nxt(); drive(1, S_NONE, D_LDP, 5);
        nxt(); drive(1, S_POP, D_PUSH, 0);
        @(negedge clk);
        chk("t3_prp",   32'(bus.prp),   1);
        chk("t3_pdla",  32'(bus.pdla),  5);
        chk("t3_stall", 32'(bus.stall), 0);
        nxt(); drive(0, 0, 0, 0);
        @(negedge clk);
        chk("t3_pwp",  32'(bus.pwp),    1);
        chk("t3_wa",   32'(bus.pdla),   5);
        chk("t3_ptr",  32'(bus.pdlptr), 5);

        // Index path
        nxt(); drive(1, S_NONE, D_LDX, 'h2A0);
        nxt(); drive(1, S_NONE, D_IDX, 0);
        @(negedge clk); chk("t4_idx", 32'(bus.pdlidx), 'h2A0);
        nxt(); drive(1, S_IDX, D_NONE, 0);
        @(negedge clk);
        chk("t4_pwp",   32'(bus.pwp),    1);
        chk("t4_wa",    32'(bus.pdla),   'h2A0);
        chk("t4_stall", 32'(bus.stall),  1);
        chk("t4_ptr_a", 32'(bus.pdlptr), 5);
        nxt();
        @(negedge clk);
        chk("t4_prp",   32'(bus.prp),    1);
        chk("t4_ra",    32'(bus.pdla),   'h2A0);
        chk("t4_stall2",32'(bus.stall),  0);
        nxt(); drive(0, 0, 0, 0);
        @(negedge clk); chk("t4_ptr_b", 32'(bus.pdlptr), 5);

        // Back-to-back pushes
        nxt(); drive(1, S_NONE, D_LDP, 0);
        for (int i = 1; i <= 4; i++) begin
            nxt();
            if (i <= 3) drive(1, S_NONE, D_PUSH, 0); else drive(0, 0, 0, 0);
            @(negedge clk);
            chk("t5_stall", 32'(bus.stall), 0);
            if (i >= 2) begin
                chk("t5_pwp",  32'(bus.pwp),  1);
                chk("t5_pdla", 32'(bus.pdla), 32'(i - 1));
            end
        end
        chk("t5_ptr", 32'(bus.pdlptr), 3);

        // Async reset while a write is pending
        nxt(); drive(1, S_NONE, D_LDP, 6);
        nxt(); drive(1, S_NONE, D_PUSH, 0);
        nxt(); drive(1, S_PTR, D_NONE, 0);
        #1 chk("t6_pre_stall", 32'(bus.stall), 1);
        chk("t6_pre_ptr", 32'(bus.pdlptr), 7);
        #1 reset = 1'b0;
        #1;
        chk("t6_pwp",   32'(bus.pwp),      0);
        chk("t6_prp",   32'(bus.prp),      0);
        chk("t6_stall", 32'(bus.stall),    0);
        chk("t6_rdv",   32'(bus.rd_valid), 0);
        chk("t6_ptr",   32'(bus.pdlptr),   0);
        nxt();
        chk("t6_hold_prp", 32'(bus.prp), 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("t6_after_pwp", 32'(bus.pwp), 0);
        nxt();

        // Randomized run against the model
        held = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!held) begin
                r = $urandom_range(0, 4);
                drive(($urandom_range(0, 9) != 0) ? 1 : 0,
                      $urandom_range(0, 3), $urandom_range(0, 7),
                      (r == 0) ? 0 : (r == 1) ? DEPTH - 1 : (r == 2) ? 1 : $urandom_range(0, DEPTH - 1));
            end
            @(negedge clk);
            held = bus.op_valid && bus.stall;
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b0;
                #1;
                chk("r_rst_pwp",   32'(bus.pwp),    0);
                chk("r_rst_prp",   32'(bus.prp),    0);
                chk("r_rst_stall", 32'(bus.stall),  0);
                chk("r_rst_ptr",   32'(bus.pdlptr), 0);
                @(posedge clk);
                #2 reset = 1'b1;
                held = 0;
            end
            nxt();
        end

        drive(0, 0, 0, 0);
        repeat (2) nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
